// File: rtl/mc_riscv_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// datapath select codes and the decode-stage dispatch function.
package mc_riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
        S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JALR_ADR, S_JAL, S_ILLEGAL
    } state_e;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_PASSB = 2'b11;

    // State entered after DECODE for a given opcode.
    function automatic state_e op_next(logic [6:0] op);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXECR;
            OP_ITYPE:          return S_EXECI;
            OP_BRANCH:         return S_BRANCH;
            OP_JAL:            return S_JAL;
            OP_JALR:           return S_JALR_ADR;
            OP_LUI:            return S_LUI;
            default:           return S_ILLEGAL;
        endcase
    endfunction

endpackage

// File: rtl/mc_riscv_controller_branch_cond.sv
// Branch condition evaluation from funct3 and the ALU compare flags.
// Unsupported funct3 codes (BLTU/BGEU/reserved) resolve as not taken.
module mc_branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       take
);

    // Select the flag (or its inverse) that decides the branch.
    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = zero;
            3'b001:  take = !zero;
            3'b100:  take = lt;
            3'b101:  take = !lt;
            default: take = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_riscv_controller.sv
// Multicycle RV32I controller: Moore FSM driving datapath selects/enables,
// memory request handshake and a watchdog on mem_ready.
// Optional macro MC_PERF_CNT_EN adds cycle/instret/stall counters.
module mc_riscv_controller
    import mc_riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_error
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    localparam int WD_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

    state_e          state_q, state_d;
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic [WD_W:0]   wd_inc;
    logic            illegal_q, illegal_d;
    logic            bus_error_q, bus_error_d;
    logic            take;

    mc_branch_cond u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .take   (take)
    );

    // Next state, Moore outputs and memory watchdog.
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        bus_error_d = bus_error_q;
        wd_cnt_d    = '0;
        wd_inc      = {1'b0, wd_cnt_q} + 1'b1;
        mem_req     = 1'b0;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        ResultSrc   = RES_ALUOUT;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_RD2;
        ALUOp       = ALUOP_ADD;
        ImmSrc      = IMM_I;
        RegWrite    = 1'b0;
        instr_done  = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALURES;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_B;
                state_d = op_next(op);
                if (op_next(op) == S_ILLEGAL) illegal_d = 1'b1;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                // IR still holds the instruction, so op selects load vs store.
                if (op == OP_STORE) begin
                    ImmSrc  = IMM_S;
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RD1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcB = SRCB_IMM;
                ImmSrc  = IMM_U;
                ALUOp   = ALUOP_PASSB;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA    = SRCA_RD1;
                ALUOp      = ALUOP_SUB;
                PCWrite    = take;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_JALR_ADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = S_JAL;
            end
            S_JAL: begin
                // Target already in ALUOut; ALU forms the link value OldPC+4.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_4;
                PCWrite = 1'b1;
                state_d = S_ALUWB;
            end
            S_ILLEGAL: state_d = S_ILLEGAL;
            default:   state_d = S_ILLEGAL;
        endcase

        // Watchdog counts unanswered request cycles; any non-waiting cycle clears it.
        if (mem_req && !mem_ready) begin
            wd_cnt_d = wd_inc[WD_W-1:0];
            if (MEM_TIMEOUT != 0 && 32'(wd_inc) >= 32'(MEM_TIMEOUT)) begin
                bus_error_d = 1'b1;
                state_d     = S_ILLEGAL;
                wd_cnt_d    = '0;
            end
        end

        // Reset must silence the bus immediately, not at the next edge.
        if (!rst_n) begin
            mem_req    = 1'b0;
            PCWrite    = 1'b0;
            AdrSrc     = 1'b0;
            MemWrite   = 1'b0;
            IRWrite    = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUOp      = 2'b00;
            ImmSrc     = 3'b000;
            RegWrite   = 1'b0;
            instr_done = 1'b0;
        end
    end

    // State, sticky fault flags and watchdog counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            wd_cnt_q    <= '0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wd_cnt_q    <= wd_cnt_d;
            illegal_q   <= illegal_d;
            bus_error_q <= bus_error_d;
        end
    end

    assign illegal   = illegal_q;
    assign bus_error = bus_error_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Free-running counters; they wrap naturally at 2^CNT_W.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q + 1'b1;
        instret_cnt_d = instret_cnt_q + CNT_W'(instr_done);
        stall_cnt_d   = stall_cnt_q + CNT_W'(mem_req && !mem_ready);
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
    assign stall_cnt   = stall_cnt_q;
`else
    logic cnt_w_unused;
    assign cnt_w_unused = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_mc_riscv_controller.sv
// Self-checking bench for mc_riscv_controller: directed scenarios plus a
// randomized instruction stream checked against a per-instruction cycle model.
module tb_mc_riscv_controller;

    localparam int TO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] op = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic       zero = 1'b0;
    logic       lt = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
    logic [2:0] ImmSrc;
    logic       RegWrite, instr_done, illegal, bus_error;
`ifdef MC_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt, stall_cnt;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mc_riscv_controller #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero), .lt(lt),
        .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .RegWrite(RegWrite),
        .instr_done(instr_done), .illegal(illegal), .bus_error(bus_error)
`ifdef MC_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt), .stall_cnt(stall_cnt)
`endif
    );

    typedef struct {
        logic       rdy;
        logic       z;
        logic       l;
        logic [6:0] v;   // {mem_req, IRWrite, PCWrite, RegWrite, instr_done, MemWrite, AdrSrc}
    } cyc_t;

    function automatic cyc_t mk(logic rdy, logic [6:0] v);
        cyc_t c;
        c.rdy = rdy;
        c.z   = 1'($urandom);
        c.l   = 1'($urandom);
        c.v   = v;
        return c;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [19:0] o;
        logic [7:0]  f;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        o = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
             ALUOp, ImmSrc, RegWrite, instr_done, illegal, bus_error};
        total++;
        if (o !== 20'd0) begin bad++; $display("FAIL reset_outputs got=%b exp=0", o); end
`ifdef MC_PERF_CNT_EN
        total++;
        if ({cycle_cnt, instret_cnt, stall_cnt} !== 96'd0) begin
            bad++; $display("FAIL reset_counters got=%0d/%0d/%0d exp=0", cycle_cnt, instret_cnt, stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
        #1;
        f = {mem_req, IRWrite, PCWrite, AdrSrc, ResultSrc, ALUSrcB};
        total++;
        if (f !== 8'b1000_10_10) begin bad++; $display("FAIL reset_fetch got=%b exp=10001010", f); end
        @(negedge clk);
    endtask

    task automatic test_rtype();
        // {mem_req, IRWrite, PCWrite, RegWrite, instr_done, ALUSrcA, ALUSrcB, ALUOp}
        logic [10:0] exp [5] = '{11'b11100_00_10_00, 11'b00000_01_01_00,
                                 11'b00000_10_00_10, 11'b00011_00_00_00,
                                 11'b11100_00_10_00};
        logic [10:0] o;
        do_reset();
        op = 7'b0110011;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            o = {mem_req, IRWrite, PCWrite, RegWrite, instr_done, ALUSrcA, ALUSrcB, ALUOp};
            total++;
            if (o !== exp[i]) begin bad++; $display("FAIL rtype c%0d got=%b exp=%b", i + 1, o, exp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_wait();
        // {mem_req, AdrSrc, RegWrite, instr_done, ResultSrc, ImmSrc}
        logic [8:0] exp [8] = '{9'b1000_10_000, 9'b0000_00_010, 9'b0000_00_000,
                                9'b1100_00_000, 9'b1100_00_000, 9'b1100_00_000,
                                9'b0011_01_000, 9'b1000_10_000};
        logic       rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [8:0] o;
        do_reset();
        op = 7'b0000011;
        funct3 = 3'b010;
        for (int i = 0; i < 8; i++) begin
            mem_ready = rdy[i];
            #1;
            o = {mem_req, AdrSrc, RegWrite, instr_done, ResultSrc, ImmSrc};
            total++;
            if (o !== exp[i]) begin bad++; $display("FAIL load_wait c%0d got=%b exp=%b", i + 1, o, exp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_branches();
        logic [2:0] f3 [4] = '{3'b000, 3'b001, 3'b101, 3'b010};
        logic       zz [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic       ll [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       tk [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [6:0] o;
        do_reset();
        op = 7'b1100011;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            funct3 = f3[i];
            zero = zz[i];
            lt = ll[i];
            @(negedge clk);
            @(negedge clk);
            #1;
            // {PCWrite, instr_done, ALUOp, ALUSrcA, mem_req}
            o = {PCWrite, instr_done, ALUOp, ALUSrcA, mem_req};
            total++;
            if (o !== {tk[i], 1'b1, 2'b01, 2'b10, 1'b0}) begin
                bad++; $display("FAIL branch f3=%b got=%b exp=%b", f3[i], o, {tk[i], 1'b1, 2'b01, 2'b10, 1'b0});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jalr();
        // {PCWrite, RegWrite, instr_done, ALUSrcA, ALUSrcB, ImmSrc}
        logic [9:0] exp [5] = '{10'b100_00_10_000, 10'b000_01_01_010, 10'b000_10_01_000,
                                10'b100_01_10_000, 10'b011_00_00_000};
        logic [9:0] o;
        do_reset();
        op = 7'b1100111;
        mem_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            o = {PCWrite, RegWrite, instr_done, ALUSrcA, ALUSrcB, ImmSrc};
            total++;
            if (o !== exp[i]) begin bad++; $display("FAIL jalr c%0d got=%b exp=%b", i + 1, o, exp[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal();
        logic [7:0] o;
        do_reset();
        op = 7'b1111111;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            mem_ready = 1'($urandom);
            #1;
            o = {mem_req, IRWrite, PCWrite, RegWrite, MemWrite, instr_done, illegal, bus_error};
            total++;
            if (o !== 8'b0000_0010) begin bad++; $display("FAIL illegal c%0d got=%b exp=00000010", i, o); end
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (illegal !== 1'b0) begin bad++; $display("FAIL illegal_clear got=%b exp=0", illegal); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [2:0] o;
        do_reset();
        op = 7'b0110011;
        mem_ready = 1'b0;
        for (int i = 0; i < TO + 3; i++) begin
            #1;
            o = {mem_req, bus_error, illegal};
            total++;
            if (i < TO) begin
                if (o !== 3'b100) begin bad++; $display("FAIL timeout_wait c%0d got=%b exp=100", i, o); end
            end else begin
                if (o !== 3'b010) begin bad++; $display("FAIL timeout_err c%0d got=%b exp=010", i, o); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [2:0] o;
        do_reset();
        op = 7'b0100011;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        o = {mem_req, MemWrite, AdrSrc};
        total++;
        if (o !== 3'b111) begin bad++; $display("FAIL memwrite_state got=%b exp=111", o); end
        #2;
        rst_n = 1'b0;
        #1;
        o = {mem_req, MemWrite, AdrSrc};
        total++;
        if (o !== 3'b000) begin bad++; $display("FAIL reset_mid_write got=%b exp=000", o); end
`ifdef MC_PERF_CNT_EN
        total++;
        if ({cycle_cnt, instret_cnt, stall_cnt} !== 96'd0) begin
            bad++; $display("FAIL reset_mid_counters got=%0d/%0d/%0d exp=0", cycle_cnt, instret_cnt, stall_cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        o = {mem_req, MemWrite, AdrSrc};
        total++;
        if (o !== 3'b100 || ALUSrcB !== 2'b10) begin
            bad++; $display("FAIL after_reset_fetch got=%b/%b exp=100/10", o, ALUSrcB);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [6:0] ops [8] = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0000011,
                                7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
        cyc_t q[$];
        cyc_t c;
        int   k, fw, mw, ncyc, nstall, ninstr;
        logic tk;
        logic [6:0] o;
        do_reset();
        ncyc = 0;
        nstall = 0;
        ninstr = 40;
        for (int n = 0; n < ninstr; n++) begin
            k = $urandom_range(0, 7);
            op = ops[k];
            funct3 = 3'($urandom);
            fw = $urandom_range(0, TO - 1);
            mw = $urandom_range(0, TO - 1);
            q.delete();
            for (int w = 0; w < fw; w++) q.push_back(mk(1'b0, 7'b1000000));
            q.push_back(mk(1'b1, 7'b1110000));
            q.push_back(mk(1'($urandom), 7'b0000000));
            nstall += fw;
            case (k)
                3: begin
                    q.push_back(mk(1'($urandom), 7'b0000000));
                    for (int w = 0; w < mw; w++) q.push_back(mk(1'b0, 7'b1000001));
                    q.push_back(mk(1'b1, 7'b1000001));
                    q.push_back(mk(1'($urandom), 7'b0001100));
                    nstall += mw;
                end
                4: begin
                    q.push_back(mk(1'($urandom), 7'b0000000));
                    for (int w = 0; w < mw; w++) q.push_back(mk(1'b0, 7'b1000011));
                    q.push_back(mk(1'b1, 7'b1000111));
                    nstall += mw;
                end
                5: begin
                    c = mk(1'($urandom), 7'b0);
                    case (funct3)
                        3'b000:  tk = c.z;
                        3'b001:  tk = !c.z;
                        3'b100:  tk = c.l;
                        3'b101:  tk = !c.l;
                        default: tk = 1'b0;
                    endcase
                    c.v = {2'b00, tk, 1'b0, 1'b1, 2'b00};
                    q.push_back(c);
                end
                6: begin
                    q.push_back(mk(1'($urandom), 7'b0010000));
                    q.push_back(mk(1'($urandom), 7'b0001100));
                end
                7: begin
                    q.push_back(mk(1'($urandom), 7'b0000000));
                    q.push_back(mk(1'($urandom), 7'b0010000));
                    q.push_back(mk(1'($urandom), 7'b0001100));
                end
                default: begin
                    q.push_back(mk(1'($urandom), 7'b0000000));
                    q.push_back(mk(1'($urandom), 7'b0001100));
                end
            endcase
            foreach (q[i]) begin
                mem_ready = q[i].rdy;
                zero = q[i].z;
                lt = q[i].l;
                #1;
                o = {mem_req, IRWrite, PCWrite, RegWrite, instr_done, MemWrite, AdrSrc};
                total++;
                if (o !== q[i].v) begin
                    bad++; $display("FAIL rand n=%0d op=%b c%0d got=%b exp=%b", n, op, i, o, q[i].v);
                end
                ncyc++;
                @(negedge clk);
            end
        end
        total++;
        if ({illegal, bus_error} !== 2'b00) begin bad++; $display("FAIL rand_flags got=%b exp=00", {illegal, bus_error}); end
`ifdef MC_PERF_CNT_EN
        total++;
        if (cycle_cnt !== 32'(ncyc) || instret_cnt !== 32'(ninstr) || stall_cnt !== 32'(nstall)) begin
            bad++; $display("FAIL perf got=%0d/%0d/%0d exp=%0d/%0d/%0d", cycle_cnt, instret_cnt, stall_cnt, ncyc, ninstr, nstall);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL sim_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        test_reset();
        test_rtype();
        test_load_wait();
        test_branches();
        test_jalr();
        test_illegal();
        test_timeout();
        test_reset_mid_write();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_riscv_controller.md
Name: mc_riscv_controller

Overview:
Moore-style FSM that sequences the shared multicycle RV32I datapath: one ALU, one unified memory port, IR/OldPC/ALUOut/Data registers. It decodes the opcode held in IR, steps each instruction through fetch/decode/execute/memory/writeback, and drives all datapath selects and enables. It also owns the memory request handshake and a watchdog on that handshake. ALU function decoding (ALUOp, funct3, funct7 to ALU control) stays in the existing downstream ALU decoder.

Parameters:
MEM_TIMEOUT, 16, max wait cycles for mem_ready before bus_error; 0 disables the watchdog
CNT_W, 32, width of the performance counters (PERF_CNT_EN only)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
op  in  7  IR[6:0]
funct3  in  3  IR[14:12]
zero  in  1  ALU result == 0
lt  in  1  ALU signed less-than flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access request
PCWrite  out  1  PC load enable
AdrSrc  out  1  0 = PC, 1 = ALUOut
MemWrite  out  1  store strobe (qualified by mem_req)
IRWrite  out  1  IR and OldPC load enable
ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = const 4
ALUOp  out  2  00 = add, 01 = compare (sub), 10 = funct-decoded, 11 = pass B
ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = U, 100 = J
RegWrite  out  1  register file write enable
instr_done  out  1  1-cycle pulse on the cycle the last state of an instruction is active
illegal  out  1  sticky: unknown opcode decoded
bus_error  out  1  sticky: memory watchdog expired

Behaviour:
- Reset, asynchronous, rst_n low: state = FETCH; all enables and strobes, illegal, bus_error and the watchdog counter go to 0; all selects go to 0.
- Outputs are a pure function of the state, except PCWrite in BRANCH and the mem_ready qualification shown below. Output bits not listed for a state are 0.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite and PCWrite are asserted only when mem_ready=1, and the FSM then moves to DECODE. Otherwise it stays in FETCH. mem_ready arriving in the same cycle mem_req rises is a zero-wait access.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00, ImmSrc=010 (branch/JAL target into ALUOut). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR_ADR
  - 0110111 -> LUI
  - anything else -> ILLEGAL
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00, ImmSrc=000 for loads and 001 for stores. Next: MEMREAD for loads, MEMWRITE for stores.
- MEMREAD: mem_req=1, AdrSrc=1. Moves to MEMWB on mem_ready, otherwise holds.
- MEMWB: ResultSrc=01, RegWrite=1. Next: FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1. Moves to FETCH on mem_ready, otherwise holds.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next: ALUWB.
- EXECI: as EXECR but ALUSrcB=01, ImmSrc=000. Next: ALUWB.
- LUI: ALUSrcB=01, ImmSrc=011, ALUOp=11. Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Next: FETCH.
- BRANCH: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00. PCWrite=take, where take is:
  - funct3 000: zero
  - funct3 001: !zero
  - funct3 100: lt
  - funct3 101: !lt
  - any other funct3: 0 (not taken)
  Next: FETCH.
- JALR_ADR: ALUSrcA=10, ALUSrcB=01, ImmSrc=000, ALUOp=00 (target into ALUOut). Next: JAL.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1 (link value OldPC+4 into ALUOut). Next: ALUWB.
- ILLEGAL: illegal=1, all enables 0. Holds until reset.
- Zero-wait latencies in cycles: branch 3; R/I/LUI/store/JAL 4; load/JALR 5. Each memory wait cycle adds 1.
- instr_done is asserted in MEMWB, MEMWRITE (when mem_ready), ALUWB and BRANCH.
- Watchdog:
  - The counter increments each cycle that mem_req=1 and mem_ready=0, and clears on mem_ready or when leaving a memory state.
  - When it reaches MEM_TIMEOUT: bus_error is set and the FSM moves to ILLEGAL (illegal stays 0 on this path).
- Reset mid-access drops mem_req immediately, asynchronously.

Optional Feature:
Macro: MC_PERF_CNT_EN
- Defined:
  - Adds outputs cycle_cnt[CNT_W-1:0] (increments every cycle out of reset) and instret_cnt[CNT_W-1:0] (increments on instr_done).
  - Adds output stall_cnt[CNT_W-1:0] (increments on mem_req & !mem_ready).
  - All three reset to 0 and wrap modulo 2^CNT_W.
- Undefined: these ports and registers do not exist. FSM behaviour is identical either way.

Decomposition:
- Package mc_riscv_pkg holds:
  - opcode constants
  - state encoding, 4-bit, 14 states
  - ImmSrc, ResultSrc, ALUSrcA/B and ALUOp encodings
- Sub-module mc_branch_cond: combinational funct3/zero/lt -> take.
- The FSM, output decode and watchdog stay in mc_riscv_controller.

Test Plan:
- R-type: op=0110011, mem_ready tied 1 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4; instr_done pulses in cycle 4.
- Load with 2 wait cycles: op=0000011, mem_ready low for 2 cycles in MEMREAD -> AdrSrc=1 and mem_req held 3 cycles; MEMWB has ResultSrc=01; total 7 cycles.
- Branches: funct3=000 with zero=1 -> PCWrite=1; funct3=001 with zero=1 -> PCWrite=0; funct3=101 with lt=0 -> PCWrite=1; funct3=010 -> PCWrite=0.
- JALR: op=1100111 -> FETCH, DECODE, JALR_ADR, JAL, ALUWB; PCWrite high only in JAL; JAL state drives ALUSrcA=01, ALUSrcB=10.
- Faults:
  - op=1111111 -> ILLEGAL, illegal=1, no enables until rst_n low.
  - With MEM_TIMEOUT=4 and mem_ready stuck 0 in FETCH -> bus_error=1 after 4 wait cycles.
- Reset mid-MEMWRITE: rst_n low -> mem_req and MemWrite drop the same cycle; after release the FSM is in FETCH. With MC_PERF_CNT_EN defined, counters read 0.
